// File: rtl/barrel_shift_sel.sv
// 32-bit SLL/SRL log shifter (16/8/4/2/1 stages); rotate option via BARREL_SHIFT_ROTATE_EN.
// Latency 1 cycle (registered output); no backpressure, the register updates every cycle.
module barrel_shift_sel (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  shift_amnt,
   input  logic        L_R,
   input  logic [31:0] shift_str,
`ifdef BARREL_SHIFT_ROTATE_EN
   input  logic        rot,
`endif
   output logic [31:0] shifted_str
);

   logic        rot_en;
   logic [5:0][31:0] stage_w;
   logic [31:0] shifted_d;
   logic [31:0] shifted_q;

`ifdef BARREL_SHIFT_ROTATE_EN
   assign rot_en = rot;
`else
   assign rot_en = 1'b0;
`endif

   assign stage_w[0] = shift_str;

   // Stage i shifts by 2^(4-i); bits falling off one end re-enter the other only when rotating.
   for (genvar i = 0; i < 5; i++) begin : g_stage
      localparam int K = 4 - i;
      localparam int S = 1 << K;

      logic [S-1:0]  lo_bits;
      logic [S-1:0]  hi_bits;
      logic [S-1:0]  fill_r;
      logic [S-1:0]  fill_l;
      logic [31:0]   r_val;
      logic [31:0]   l_val;

      assign lo_bits = stage_w[i][S-1:0];
      assign hi_bits = stage_w[i][31:32-S];
      assign fill_r  = rot_en ? lo_bits : {S{1'b0}};
      assign fill_l  = rot_en ? hi_bits : {S{1'b0}};
      assign r_val   = {fill_r, stage_w[i][31:S]};
      assign l_val   = {stage_w[i][31-S:0], fill_l};

      assign stage_w[i+1] = !shift_amnt[K] ? stage_w[i] :
                            (L_R ? r_val : l_val);
   end

   assign shifted_d = stage_w[5];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shifted_q <= 32'h0000_0000;
      end else begin
         shifted_q <= shifted_d;
      end
   end

   assign shifted_str = shifted_q;

endmodule

// File: tb/tb_barrel_shift_sel.sv
// Self-checking bench for barrel_shift_sel: directed vectors, random vectors vs an
// arithmetic reference, asynchronous reset and between-edge input changes.
module tb_barrel_shift_sel;

   logic        clk;
   logic        rst_n;
   logic [4:0]  shift_amnt;
   logic        L_R;
   logic [31:0] shift_str;
   logic        rot;
   logic [31:0] shifted_str;

   int checks;
   int errors;

   barrel_shift_sel dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .shift_amnt  (shift_amnt),
      .L_R         (L_R),
      .shift_str   (shift_str),
`ifdef BARREL_SHIFT_ROTATE_EN
      .rot         (rot),
`endif
      .shifted_str (shifted_str)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a 64-bit window shift; the part pushed outside the 32-bit word is
   // the rotated-out portion, OR'ed back in when rotating.
   function automatic logic [31:0] ref_f(input logic [31:0] w, input int a,
                                         input bit right, input bit r);
      logic [63:0] d;
      if (!right) begin
         d = {32'h0, w} << a;
         return d[31:0] | (r ? d[63:32] : 32'h0);
      end else begin
         d = {w, 32'h0} >> a;
         return d[63:32] | (r ? d[31:0] : 32'h0);
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] exp);
      checks++;
      assert (shifted_str === exp)
         else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, shifted_str, exp);
         end
   endtask

   // Drive at negedge, check #1 after the capturing edge, then disturb the inputs
   // and confirm the registered output holds until the next edge.
   task automatic apply(input string tag, input logic [31:0] w, input logic [4:0] a,
                        input logic d, input logic r, input logic [31:0] exp);
      @(negedge clk);
      shift_str  = w;
      shift_amnt = a;
      L_R        = d;
      rot        = r;
      @(posedge clk);
      #1;
      check(tag, exp);
      shift_str  = ~w;
      shift_amnt = a + 5'd7;
      L_R        = ~d;
      #2;
      check({tag, "_hold"}, exp);
   endtask

   initial begin
      logic [31:0] w;
      logic [4:0]  a;
      logic        d;
      logic        r;

      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      shift_str  = 32'hDEAD_BEEF;
      shift_amnt = 5'd3;
      L_R        = 1'b0;
      rot        = 1'b0;
      #2;
      check("reset_init", 32'h0);
      @(posedge clk);
      #1;
      check("reset_held_over_edge", 32'h0);

      @(negedge clk);
      rst_n = 1'b1;

      apply("sll4",   32'hD6975971, 5'd4,  1'b0, 1'b0, 32'h69759710);
      apply("srl2",   32'hD6975971, 5'd2,  1'b1, 1'b0, 32'h35A5D65C);
      apply("srl3",   32'hD6975971, 5'd3,  1'b1, 1'b0, 32'h1AD2EB2E);
      apply("sll5",   32'hD6975971, 5'd5,  1'b0, 1'b0, 32'hD2EB2E20);
      apply("srl10",  32'hD6975971, 5'd10, 1'b1, 1'b0, 32'h0035A5D6);
      apply("sll0",   32'hD6975971, 5'd0,  1'b0, 1'b0, 32'hD6975971);
      apply("srl0",   32'hD6975971, 5'd0,  1'b1, 1'b0, 32'hD6975971);
      apply("sll31",  32'hD6975971, 5'd31, 1'b0, 1'b0, 32'h80000000);
      apply("srl31",  32'hD6975971, 5'd31, 1'b1, 1'b0, 32'h00000001);
      apply("srl_nosext", 32'h80000000, 5'd16, 1'b1, 1'b0, 32'h00008000);
`ifdef BARREL_SHIFT_ROTATE_EN
      apply("rol4",   32'hD6975971, 5'd4,  1'b0, 1'b1, 32'h6975971D);
      apply("ror4",   32'hD6975971, 5'd4,  1'b1, 1'b1, 32'h1D697597);
      apply("ror31",  32'hD6975971, 5'd31, 1'b1, 1'b1, 32'hAD2EB2E3);
`endif

      for (int i = 0; i < 200; i++) begin
         w = $urandom;
         a = 5'($urandom_range(0, 31));
         d = 1'($urandom_range(0, 1));
`ifdef BARREL_SHIFT_ROTATE_EN
         r = 1'($urandom_range(0, 1));
`else
         r = 1'b0;
`endif
         apply("random", w, a, d, r, ref_f(w, int'(a), d, r));
      end

      // Mid-stream asynchronous reset, away from any clock edge.
      @(negedge clk);
      shift_str  = 32'hFFFF_FFFF;
      shift_amnt = 5'd1;
      L_R        = 1'b1;
      rot        = 1'b0;
      @(posedge clk);
      #2;
      check("pre_reset", 32'h7FFF_FFFF);
      rst_n = 1'b0;
      #1;
      check("async_reset", 32'h0);
      @(posedge clk);
      #1;
      check("async_reset_held", 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      apply("after_reset", 32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
